scan_link_arbiter: RTL and testbench

Controller that sequences two scanner blocks sharing one downstream data path. It issues start and release codes on each scanner's 2-bit control input and deserializes each scanner's MSB-first command/data bit stream. It grants the transfer slot (`readyForTransfer`) to one scanner at a time and forwards recovered data bytes downstream. It sits between the two scanners and the host-side byte consumer.

---
 rtl/scan_link_if.sv | 30 +++
 rtl/scan_link_arbiter.sv | 250 +++++++++++++++++++++++++
 tb/tb_scan_link_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_link_if.sv
// Signal bundle between the scan link arbiter and its environment:
// scanner serial links, scanner control codes, grants and the downstream byte port.
interface scan_link_if;
    logic       start;
    logic       s0_bit_valid;
    logic       s0_bit;
    logic       s1_bit_valid;
    logic       s1_bit;
    logic [1:0] s0_ctrl;
    logic [1:0] s1_ctrl;
    logic       s0_grant;
    logic       s1_grant;
    logic       data_valid;
    logic [7:0] data_out;
    logic       data_src;
    logic       busy;
    logic       err;

    modport slave (
        input  start, s0_bit_valid, s0_bit, s1_bit_valid, s1_bit,
        output s0_ctrl, s1_ctrl, s0_grant, s1_grant,
        output data_valid, data_out, data_src, busy, err
    );

    modport master (
        output start, s0_bit_valid, s0_bit, s1_bit_valid, s1_bit,
        input  s0_ctrl, s1_ctrl, s0_grant, s1_grant,
        input  data_valid, data_out, data_src, busy, err
    );
endinterface

// File: rtl/scan_link_arbiter.sv
// Sequences two scanners sharing one downstream byte path: deserializes their
// command/data streams, hands out the transfer grant and forwards data bytes.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start, all outputs quiet except sticky err
// S_SCAN    | scanners running, waiting for a transfer request
// S_GRANT0  | scanner 0 owns the transfer slot, timeout counter running
// S_GRANT1  | scanner 1 owns the transfer slot, timeout counter running
// S_RELEASE | one cycle: release code to the served scanner, flags cleared
module scan_link_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    scan_link_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_GRANT0,
        S_GRANT1,
        S_RELEASE
    } state_t;

    localparam logic [1:0] CTRL_NONE    = 2'b00;
    localparam logic [1:0] CTRL_START   = 2'b01;
    localparam logic [1:0] CTRL_RELEASE = 2'b10;

    state_t state_q, state_d;

    logic [1:0]       bv, bd;
    logic [1:0]       word_done;
    logic [1:0][7:0]  word;

    // Seven bits are enough: the eighth bit of a word comes straight off the line.
    logic [1:0][6:0]  shift_q, shift_d;
    logic [1:0][2:0]  cnt_q, cnt_d;
    logic [1:0]       hdr_q, hdr_d;
    logic [1:0]       req_q, req_d;
    logic [1:0]       full_q, full_d;
    logic [1:0]       got_q, got_d;
    logic [1:0]       active_q, active_d;
    logic [1:0]       pend_q, pend_d;
    logic             last_q, last_d;
    logic             cur_q, cur_d;
    logic [15:0]      tmr_q, tmr_d;

    logic [1:0][1:0]  ctrl_q, ctrl_d;
    logic [1:0]       grant_q, grant_d;
    logic             dv_q, dv_d;
    logic [7:0]       dout_q, dout_d;
    logic             src_q, src_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic             pick;
    logic             ii, oo;

    assign bv = {bus.s1_bit_valid, bus.s0_bit_valid};
    assign bd = {bus.s1_bit, bus.s0_bit};

    assign word_done = bv & {cnt_q[1] == 3'd7, cnt_q[0] == 3'd7};
    assign word[0]   = {shift_q[0], bd[0]};
    assign word[1]   = {shift_q[1], bd[1]};

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        hdr_d    = hdr_q;
        req_d    = req_q;
        full_d   = full_q;
        got_d    = got_q;
        active_d = active_q;
        pend_d   = pend_q;
        last_d   = last_q;
        cur_d    = cur_q;
        tmr_d    = tmr_q;
        ctrl_d   = '0;
        grant_d  = '0;
        dv_d     = 1'b0;
        dout_d   = '0;
        src_d    = 1'b0;
        busy_d   = 1'b0;
        err_d    = err_q;
        pick     = 1'b0;
        ii       = 1'b0;
        oo       = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    ctrl_d[0]   = CTRL_START;
                    active_d[0] = 1'b1;
                    pend_d[0]   = 1'b0;
                    state_d     = S_SCAN;
                end
            end
            S_SCAN: begin
                if (req_q == 2'b00) begin
                    if (active_q == 2'b00 && pend_q == 2'b00) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    if (req_q == 2'b11) begin
                        // A full buffer outranks round-robin; ties go to the scanner not served last.
                        pick = (full_q[0] != full_q[1]) ? full_q[1] : ~last_q;
                    end else begin
                        pick = req_q[1];
                    end
                    cur_d   = pick;
                    state_d = pick ? S_GRANT1 : S_GRANT0;
                end
            end
            S_GRANT0, S_GRANT1: begin
                if (got_q[cur_q]) begin
                    state_d = S_RELEASE;
                end else if (({1'b0, tmr_q} + 17'd1) >= 17'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            S_RELEASE: begin
                req_d[cur_q]    = 1'b0;
                full_d[cur_q]   = 1'b0;
                got_d[cur_q]    = 1'b0;
                active_d[cur_q] = 1'b0;
                tmr_d           = '0;
                last_d          = cur_q;
                state_d         = S_SCAN;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_RELEASE && state_q != S_RELEASE) begin
            ctrl_d[cur_d] = CTRL_RELEASE;
        end

        // A pending start yields to a release of the same scanner and goes out a cycle later.
        if (state_q != S_IDLE) begin
            for (int j = 0; j < 2; j++) begin
                ii = j[0];
                if (pend_q[ii] && !(state_d == S_RELEASE && cur_d == ii)) begin
                    ctrl_d[ii]   = CTRL_START;
                    active_d[ii] = 1'b1;
                    pend_d[ii]   = 1'b0;
                end
            end
        end

        for (int i = 0; i < 2; i++) begin
            ii = i[0];
            oo = ~ii;
            if (bv[ii]) begin
                shift_d[ii] = word[ii][6:0];
                cnt_d[ii]   = cnt_q[ii] + 3'd1;
            end
            if (word_done[ii]) begin
                if (hdr_q[ii]) begin
                    hdr_d[ii] = 1'b0;
                    if (grant_q[ii]) begin
                        dv_d       = 1'b1;
                        dout_d     = word[ii];
                        src_d      = ii;
                        got_d[ii]  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    case (word[ii])
                        8'd2: req_d[ii] = 1'b1;
                        8'd4: begin
                            req_d[ii]  = 1'b1;
                            full_d[ii] = 1'b1;
                        end
                        8'd3: begin
                            if (!active_d[oo]) begin
                                pend_d[oo] = 1'b1;
                            end
                        end
                        8'd7: hdr_d[ii] = 1'b1;
                        default: err_d = 1'b1;
                    endcase
                end
            end
        end

        grant_d = {state_d == S_GRANT1, state_d == S_GRANT0};
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            hdr_q    <= '0;
            req_q    <= '0;
            full_q   <= '0;
            got_q    <= '0;
            active_q <= '0;
            pend_q   <= '0;
            last_q   <= 1'b1;
            cur_q    <= 1'b0;
            tmr_q    <= '0;
            ctrl_q   <= '0;
            grant_q  <= '0;
            dv_q     <= 1'b0;
            dout_q   <= '0;
            src_q    <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            hdr_q    <= hdr_d;
            req_q    <= req_d;
            full_q   <= full_d;
            got_q    <= got_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            last_q   <= last_d;
            cur_q    <= cur_d;
            tmr_q    <= tmr_d;
            ctrl_q   <= ctrl_d;
            grant_q  <= grant_d;
            dv_q     <= dv_d;
            dout_q   <= dout_d;
            src_q    <= src_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign bus.s0_ctrl    = ctrl_q[0];
    assign bus.s1_ctrl    = ctrl_q[1];
    assign bus.s0_grant   = grant_q[0];
    assign bus.s1_grant   = grant_q[1];
    assign bus.data_valid = dv_q;
    assign bus.data_out   = dout_q;
    assign bus.data_src   = src_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_scan_link_arbiter.sv
// Directed and randomized checks of scan_link_arbiter; a second instance with a
// short timeout shares the same stimulus for the grant-timeout scenario.
module tb_scan_link_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, v0, b0, v1, b1;
    int   total = 0;
    int   bad = 0;
    int   n_s1_start = 0;

    scan_link_if bus ();
    scan_link_if bus_t ();

    assign bus.start          = start;
    assign bus.s0_bit_valid   = v0;
    assign bus.s0_bit         = b0;
    assign bus.s1_bit_valid   = v1;
    assign bus.s1_bit         = b1;
    assign bus_t.start        = start;
    assign bus_t.s0_bit_valid = v0;
    assign bus_t.s0_bit       = b0;
    assign bus_t.s1_bit_valid = v1;
    assign bus_t.s1_bit       = b1;

    scan_link_arbiter #(.TIMEOUT(64)) dut   (.clk_i(clk), .rst_i(rst), .bus(bus));
    scan_link_arbiter #(.TIMEOUT(8))  dut_t (.clk_i(clk), .rst_i(rst), .bus(bus_t));

    always @(negedge clk) if (bus.s1_ctrl == 2'b01) n_s1_start++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_pair(input logic e0, input logic [7:0] w0,
                             input logic e1, input logic [7:0] w1, input int gap_pct);
        for (int k = 7; k >= 0; k--) begin
            if (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) begin
                v0 = 1'b0;
                v1 = 1'b0;
                step();
            end
            v0 = e0;
            b0 = w0[k];
            v1 = e1;
            b1 = w1[k];
            step();
        end
        v0 = 1'b0;
        v1 = 1'b0;
        b0 = 1'b0;
        b1 = 1'b0;
    endtask

    task automatic send(input int sc, input logic [7:0] w, input int gap_pct);
        send_pair(sc == 0, w, sc == 1, w, gap_pct);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        v0 = 1'b0; b0 = 1'b0; v1 = 1'b0; b1 = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_grant(input int max_cycles, output int who);
        who = -1;
        for (int k = 0; k < max_cycles && who < 0; k++) begin
            if (bus.s0_grant === 1'b1) who = 0;
            else if (bus.s1_grant === 1'b1) who = 1;
            else step();
        end
    endtask

    initial begin
        int         who, base, gcnt, first, second, nsrv, exp_sc;
        logic       seen, e0, e1, m_last;
        logic [1:0] rel_ctrl;
        logic [7:0] w0, w1, dbyte;
        int         r0, r1;

        do_reset();
        chk("rst_s0_ctrl", bus.s0_ctrl, 0);
        chk("rst_s1_ctrl", bus.s1_ctrl, 0);
        chk("rst_s0_grant", bus.s0_grant, 0);
        chk("rst_s1_grant", bus.s1_grant, 0);
        chk("rst_dv", bus.data_valid, 0);
        chk("rst_dout", bus.data_out, 0);
        chk("rst_src", bus.data_src, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);

        // single scanner session
        pulse_start();
        chk("start_ctrl", bus.s0_ctrl, 2'b01);
        chk("start_busy", bus.busy, 1);
        step();
        chk("start_ctrl_once", bus.s0_ctrl, 2'b00);
        send(0, 8'd2, 0);
        chk("grant_not_yet", bus.s0_grant, 0);
        step();
        chk("grant_after_req", bus.s0_grant, 1);
        send(0, 8'd7, 0);
        send(0, 8'h09, 0);
        chk("single_dv", bus.data_valid, 1);
        chk("single_dout", bus.data_out, 8'h09);
        chk("single_src", bus.data_src, 0);
        step();
        chk("single_dv_once", bus.data_valid, 0);
        chk("single_grant_drop", bus.s0_grant, 0);
        chk("single_release", bus.s0_ctrl, 2'b10);
        step();
        chk("single_release_once", bus.s0_ctrl, 2'b00);
        step();
        chk("single_idle", bus.busy, 0);
        chk("single_err", bus.err, 0);

        // start handoff
        do_reset();
        pulse_start();
        step();
        base = n_s1_start;
        send(0, 8'd3, 0);
        chk("handoff_pending", bus.s1_ctrl, 2'b00);
        step();
        chk("handoff_start", bus.s1_ctrl, 2'b01);
        step();
        chk("handoff_start_end", bus.s1_ctrl, 2'b00);
        send(0, 8'd3, 0);
        repeat (4) step();
        chk("handoff_exactly_once", n_s1_start - base, 1);
        chk("handoff_err", bus.err, 0);

        // priority: full beats request, then round-robin
        do_reset();
        pulse_start();
        send_pair(1'b1, 8'd2, 1'b1, 8'd4, 0);
        step();
        chk("prio_full_s1", bus.s1_grant, 1);
        chk("prio_full_s0", bus.s0_grant, 0);
        send(1, 8'd7, 0);
        send(1, 8'hA5, 0);
        chk("prio_dv1", bus.data_valid, 1);
        chk("prio_dout1", bus.data_out, 8'hA5);
        chk("prio_src1", bus.data_src, 1);
        step();
        chk("prio_rel1", bus.s1_ctrl, 2'b10);
        wait_grant(4, who);
        chk("prio_second", who, 0);
        send(0, 8'd7, 0);
        send(0, 8'h3C, 0);
        chk("prio_dout0", bus.data_out, 8'h3C);
        chk("prio_src0", bus.data_src, 0);
        step();
        chk("prio_rel0", bus.s0_ctrl, 2'b10);
        step();
        step();
        chk("prio_idle", bus.busy, 0);
        pulse_start();
        send_pair(1'b1, 8'd2, 1'b1, 8'd2, 0);
        wait_grant(4, who);
        chk("prio_round_robin", who, 1);

        // timeout on the short-timeout instance
        do_reset();
        pulse_start();
        send(0, 8'd2, 0);
        step();
        chk("to_grant", bus_t.s0_grant, 1);
        chk("to_err_early", bus_t.err, 0);
        gcnt = 1;
        seen = 1'b0;
        rel_ctrl = 2'b00;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus_t.s0_grant === 1'b1) gcnt++;
            else if (!seen) begin
                seen = 1'b1;
                rel_ctrl = bus_t.s0_ctrl;
            end
        end
        chk("to_grant_cycles", gcnt, 8);
        chk("to_release", rel_ctrl, 2'b10);
        chk("to_err", bus_t.err, 1);
        chk("to_long_still_granted", bus.s0_grant, 1);

        // errors: bad command, data from an ungranted scanner
        do_reset();
        pulse_start();
        chk("err_clear", bus.err, 0);
        send(1, 8'h55, 0);
        chk("err_bad_cmd", bus.err, 1);
        step();
        step();
        chk("err_bad_cmd_ignored", bus.s1_grant, 0);
        do_reset();
        pulse_start();
        send(1, 8'd7, 0);
        chk("err_hdr_ok", bus.err, 0);
        send(1, 8'h33, 0);
        chk("err_ungranted_dv", bus.data_valid, 0);
        chk("err_ungranted", bus.err, 1);

        // reset mid-grant, with a partial word in flight
        do_reset();
        pulse_start();
        send(1, 8'd2, 0);
        wait_grant(4, who);
        chk("rmg_grant", who, 1);
        v0 = 1'b1;
        b0 = 1'b1;
        repeat (3) step();
        v0 = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rmg_s1_grant", bus.s1_grant, 0);
        chk("rmg_busy", bus.busy, 0);
        chk("rmg_ctrl", bus.s1_ctrl, 0);
        chk("rmg_err", bus.err, 0);
        pulse_start();
        chk("rmg_start_ctrl", bus.s0_ctrl, 2'b01);
        chk("rmg_start_busy", bus.busy, 1);
        step();
        send(0, 8'd2, 0);
        step();
        chk("rmg_fresh_word", bus.s0_grant, 1);

        // randomized request/transfer sessions against a transaction-level model
        do_reset();
        m_last = 1'b1;
        for (int it = 0; it < 12; it++) begin
            repeat (3) step();
            pulse_start();
            r0 = int'($urandom_range(2, 0));
            r1 = int'($urandom_range(2, 0));
            if (r0 == 0 && r1 == 0) r0 = 1;
            e0 = (r0 != 0);
            e1 = (r1 != 0);
            w0 = (r0 == 2) ? 8'd4 : 8'd2;
            w1 = (r1 == 2) ? 8'd4 : 8'd2;
            if (e0 && e1) begin
                if ((r0 == 2) != (r1 == 2)) first = (r1 == 2) ? 1 : 0;
                else first = m_last ? 0 : 1;
                second = 1 - first;
                nsrv = 2;
            end else begin
                first = e0 ? 0 : 1;
                second = 1 - first;
                nsrv = 1;
            end
            send_pair(e0, w0, e1, w1, 20);
            for (int s = 0; s < nsrv; s++) begin
                exp_sc = (s == 0) ? first : second;
                wait_grant(6, who);
                chk("rnd_grant", who, exp_sc);
                dbyte = 8'($urandom);
                send(exp_sc, 8'd7, 25);
                send(exp_sc, dbyte, 25);
                chk("rnd_dv", bus.data_valid, 1);
                chk("rnd_dout", bus.data_out, dbyte);
                chk("rnd_src", bus.data_src, exp_sc);
                m_last = exp_sc[0];
                step();
                chk("rnd_release", (exp_sc == 0) ? bus.s0_ctrl : bus.s1_ctrl, 2'b10);
            end
            chk("rnd_err", bus.err, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
